// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - register map, FSM encodings and helpers for the Mandelbrot generator
package fractal_pkg;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_X0   = 2'd1;
    localparam logic [1:0] REG_Y0   = 2'd2;
    localparam logic [1:0] REG_STEP = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_BUSY   = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // |z|^2 escape threshold (4.0) in the product format, which carries FRAC_BITS fraction bits
    function automatic logic [127:0] escape_r2(input int frac_bits);
        return 128'd4 << frac_bits;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur, input logic [31:0] wdata,
                                                input logic [3:0] wstrb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/fractal_iter.sv
// rtl/fractal_iter.sv - one-pixel z <- z^2 + c iteration datapath with escape test
module fractal_iter
    import fractal_pkg::*;
#(
    parameter int COORD_W   = 32,
    parameter int FRAC_BITS = 28,
    parameter int MAX_ITER  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] cr,
    input  logic signed [COORD_W-1:0] ci,
    output logic                      done,
    output logic [15:0]               n
);
    localparam int PW = 2 * COORD_W;
    localparam logic [PW:0] ESCAPE_R2 = (PW+1)'(escape_r2(FRAC_BITS));

    logic signed [COORD_W-1:0] zr, zi, cr_q, ci_q, zr_n, zi_n;
    logic signed [PW-1:0]      p_rr, p_ii, p_ri, s_rr, s_ii, s_ri;
    logic signed [PW-1:0]      q_rr, q_ii, t_rr, t_ii;
    logic [PW:0]               mag;
    logic [15:0]               n_next;
    logic                      running, escape, at_limit;

    assign p_rr = PW'(zr) * PW'(zr);
    assign p_ii = PW'(zi) * PW'(zi);
    assign p_ri = PW'(zr) * PW'(zi);
    assign s_rr = p_rr >>> FRAC_BITS;
    assign s_ii = p_ii >>> FRAC_BITS;
    // One bit less of shift folds in the factor of two of 2*zr*zi
    assign s_ri = p_ri >>> (FRAC_BITS - 1);
    assign zr_n = s_rr[COORD_W-1:0] - s_ii[COORD_W-1:0] + cr_q;
    assign zi_n = s_ri[COORD_W-1:0] + ci_q;

    // Escape is judged on the freshly computed z', so the count matches the textbook loop
    assign q_rr = PW'(zr_n) * PW'(zr_n);
    assign q_ii = PW'(zi_n) * PW'(zi_n);
    assign t_rr = q_rr >>> FRAC_BITS;
    assign t_ii = q_ii >>> FRAC_BITS;
    assign mag  = {1'b0, t_rr} + {1'b0, t_ii};

    assign escape   = mag >= ESCAPE_R2;
    assign n_next   = n + 16'd1;
    assign at_limit = n_next == 16'(MAX_ITER);
    assign done     = running && (escape || at_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zr      <= '0;
            zi      <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            n       <= '0;
            running <= 1'b0;
        end else if (start) begin
            cr_q    <= cr;
            ci_q    <= ci;
            zr      <= '0;
            zi      <= '0;
            n       <= '0;
            running <= 1'b1;
        end else if (running) begin
            zr <= zr_n;
            zi <= zi_n;
            n  <= n_next;
            if (escape || at_limit) running <= 1'b0;
        end
    end
endmodule

// File: rtl/fractal_gen.sv
// rtl/fractal_gen.sv - AXI-Lite configured Mandelbrot generator streaming iteration counts
module fractal_gen
    import fractal_pkg::*;
#(
    parameter int FRAME_W            = 1920,
    parameter int FRAME_H            = 1080,
    parameter int MAX_ITER           = 255,
    parameter int COORD_W            = 32,
    parameter int FRAC_BITS          = 28,
    parameter int M_AXIS_TDATA_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [3:0]                      s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [31:0]                     s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [3:0]                      s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [31:0]                     s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            m_axis_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
);
    localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
    localparam int TW = M_AXIS_TDATA_WIDTH;

    logic                      enable, busy, wr_hs, rd_hs, last_x, last_y, frame_start, iter_done;
    logic [31:0]               x0_reg, y0_reg, step_reg, rd_mux;
    logic signed [COORD_W-1:0] x0_sh, step_sh, cr_acc, ci_acc;
    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic [1:0]                state;
    logic [15:0]               n;
    logic                      unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign busy          = state != ST_IDLE;
    assign wr_hs         = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign rd_hs         = s_axi_arvalid && !s_axi_rvalid;
    assign s_axi_arready = !s_axi_rvalid;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            enable       <= 1'b0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            step_reg     <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wr_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= RESP_OKAY;
            case (s_axi_awaddr[3:2])
                REG_CTRL: if (s_axi_wstrb[0]) enable <= s_axi_wdata[CTRL_ENABLE];
                REG_X0:   x0_reg   <= apply_wstrb(x0_reg, s_axi_wdata, s_axi_wstrb);
                REG_Y0:   y0_reg   <= apply_wstrb(y0_reg, s_axi_wdata, s_axi_wstrb);
                default:  step_reg <= apply_wstrb(step_reg, s_axi_wdata, s_axi_wstrb);
            endcase
        end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_axi_araddr[3:2])
            REG_CTRL: begin
                rd_mux[CTRL_ENABLE] = enable;
                rd_mux[CTRL_BUSY]   = busy;
            end
            REG_X0:  rd_mux = x0_reg;
            REG_Y0:  rd_mux = y0_reg;
            default: rd_mux = step_reg;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (rd_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_mux;
            s_axi_rresp  <= RESP_OKAY;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    assign last_x = x == XW'(FRAME_W - 1);
    assign last_y = y == YW'(FRAME_H - 1);
    // Shadows reload only between frames, so register writes never tear a frame
    assign frame_start = enable && ((state == ST_IDLE) ||
                         (state == ST_OUT && m_axis_tready && last_x && last_y));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            x       <= '0;
            y       <= '0;
            x0_sh   <= '0;
            step_sh <= '0;
            cr_acc  <= '0;
            ci_acc  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enable) state <= ST_INIT;
                ST_INIT: state <= ST_ITER;
                ST_ITER: if (iter_done) state <= ST_OUT;
                default: if (m_axis_tready) begin
                    state <= ST_INIT;
                    if (!last_x) begin
                        x      <= x + 1'b1;
                        cr_acc <= cr_acc + step_sh;
                    end else begin
                        x      <= '0;
                        cr_acc <= x0_sh;
                        ci_acc <= ci_acc - step_sh;
                        y      <= last_y ? '0 : y + 1'b1;
                        if (last_y && !enable) state <= ST_IDLE;
                    end
                end
            endcase
            if (frame_start) begin
                x0_sh   <= COORD_W'(x0_reg);
                step_sh <= COORD_W'(step_reg);
                cr_acc  <= COORD_W'(x0_reg);
                ci_acc  <= COORD_W'(y0_reg);
                x       <= '0;
                y       <= '0;
            end
        end
    end

    fractal_iter #(
        .COORD_W   (COORD_W),
        .FRAC_BITS (FRAC_BITS),
        .MAX_ITER  (MAX_ITER)
    ) u_iter (
        .clk   (aclk),
        .rst   (areset),
        .start (state == ST_INIT),
        .cr    (cr_acc),
        .ci    (ci_acc),
        .done  (iter_done),
        .n     (n)
    );

    assign m_axis_tvalid = state == ST_OUT;
    assign m_axis_tstrb  = '1;
    assign m_axis_tuser  = (x == '0) && (y == '0);
    assign m_axis_tlast  = last_x;

    generate
        if (TW >= 16) begin : g_wide
            assign m_axis_tdata = TW'(n);
        end else begin : g_sat
            assign m_axis_tdata = (n > 16'((1 << TW) - 1)) ? {TW{1'b1}} : n[TW-1:0];
        end
    endgenerate
endmodule

// File: tb/tb_fractal_gen.sv
// tb/tb_fractal_gen.sv - table-driven scoreboard bench for fractal_gen on a 4x2 frame
module tb_fractal_gen;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int NPIX = FW * FH;
    localparam logic [3:0] A_CTRL = 4'h0, A_X0 = 4'h4, A_Y0 = 4'h8, A_STEP = 4'hC;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic [0:0]  m_axis_tstrb;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    fractal_gen #(
        .FRAME_W(FW), .FRAME_H(FH), .MAX_ITER(255), .COORD_W(32), .FRAC_BITS(28),
        .M_AXIS_TDATA_WIDTH(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { logic [7:0] data; logic user; logic last; } beat_t;
    typedef struct { string name; logic [31:0] x0; logic [31:0] y0; logic [31:0] step; logic [7:0][7:0] exp; } vec_t;

    beat_t q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    ready_mode = 0;
    beat_t held;
    logic  stalled = 1'b0;
    vec_t  vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out, got no response, expected one", name);
    endtask

    function automatic logic [7:0][7:0] px(input int p0, p1, p2, p3, p4, p5, p6, p7);
        return {8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] x0, y0, step, input logic [7:0][7:0] e);
        vec_t v;
        v.name = nm; v.x0 = x0; v.y0 = y0; v.step = step; v.exp = e;
        return v;
    endfunction

    task automatic push_frame(input logic [7:0][7:0] e);
        for (int i = 0; i < NPIX; i++)
            q.push_back({e[i], (i == 0), ((i % FW) == FW - 1)});
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t;
        @(posedge aclk); #1;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        t = 0;
        while (!(s_axi_awready && s_axi_wready) && t < 50) begin @(negedge aclk); t++; end
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        t = 0;
        while (!s_axi_bvalid && t < 50) begin @(negedge aclk); t++; end
        if (!s_axi_bvalid) timeout("bvalid");
        else check("bresp", 32'(s_axi_bresp), 32'd0);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        @(posedge aclk); #1;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(negedge aclk); t++; end
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        t = 0;
        while (!s_axi_rvalid && t < 50) begin @(negedge aclk); t++; end
        data = s_axi_rdata;
        if (!s_axi_rvalid) timeout("rvalid");
        else check("rresp", 32'(s_axi_rresp), 32'd0);
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        logic [31:0] d;
        t = 0;
        while (q.size() != 0 && t < 8000) begin @(negedge aclk); t++; end
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, q.size());
            q.delete();
        end
        t = 0;
        do begin axi_read(A_CTRL, d); t++; end while (d[1] && t < 50);
        check({name, "_ctrl_idle"}, d, 32'd0);
        repeat (20) @(negedge aclk);
        check({name, "_tvalid_idle"}, 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    always @(negedge aclk) begin
        beat_t got;
        beat_t exp;
        got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        if (!areset && stalled && m_axis_tvalid) check("stall_hold", 32'(got), 32'(held));
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL extra_beat: got {data,user,last}=0x%0h, expected no beat", got);
            end else begin
                exp = q.pop_front();
                check("beat{data,user,last}", 32'(got), 32'(exp));
            end
        end
        stalled = !areset && m_axis_tvalid && !m_axis_tready;
        held = got;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int t;
        vecs[0] = mk("origin", 32'h0000_0000, 32'h0000_0000, 32'h0, px(255, 255, 255, 255, 255, 255, 255, 255));
        vecs[1] = mk("c_p2",   32'h2000_0000, 32'h0000_0000, 32'h0, px(1, 1, 1, 1, 1, 1, 1, 1));
        vecs[2] = mk("c_p1",   32'h1000_0000, 32'h0000_0000, 32'h0, px(2, 2, 2, 2, 2, 2, 2, 2));
        vecs[3] = mk("c_m2",   32'hE000_0000, 32'h0000_0000, 32'h0, px(1, 1, 1, 1, 1, 1, 1, 1));
        vecs[4] = mk("c_2i",   32'h0000_0000, 32'h2000_0000, 32'h0, px(1, 1, 1, 1, 1, 1, 1, 1));
        // c runs -2,-1,0,1 along x; line 1 has ci = -1
        vecs[5] = mk("sweep",  32'hE000_0000, 32'h0000_0000, 32'h1000_0000, px(1, 255, 255, 2, 1, 3, 255, 2));

        #12;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("tstrb", 32'(m_axis_tstrb), 32'd1);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        axi_read(A_CTRL, d); check("rst_ctrl", d, 32'd0);
        axi_read(A_X0, d);   check("rst_x0", d, 32'd0);
        axi_read(A_Y0, d);   check("rst_y0", d, 32'd0);
        axi_read(A_STEP, d); check("rst_step", d, 32'd0);

        for (int v = 0; v < 6; v++) begin
            axi_write(A_X0, vecs[v].x0, 4'hF);
            axi_write(A_Y0, vecs[v].y0, 4'hF);
            axi_write(A_STEP, vecs[v].step, 4'hF);
            push_frame(vecs[v].exp);
            axi_write(A_CTRL, 32'd1, 4'hF);
            axi_write(A_CTRL, 32'd0, 4'hF);
            wait_idle(vecs[v].name);
        end

        ready_mode = 1;
        push_frame(vecs[5].exp);
        axi_write(A_CTRL, 32'd1, 4'hF);
        t = 0;
        while (q.size() > NPIX - 2 && t < 3000) begin @(negedge aclk); t++; end
        if (q.size() > NPIX - 2) timeout("two_beats");
        axi_read(A_CTRL, d); check("ctrl_busy_enabled", d, 32'd3);
        axi_write(A_CTRL, 32'd0, 4'hF);
        axi_read(A_CTRL, d); check("ctrl_busy_disabled", d, 32'd2);
        wait_idle("random_ready");
        ready_mode = 0;

        axi_write(A_X0, 32'h2000_0000, 4'hF);
        axi_write(A_Y0, 32'h0, 4'hF);
        axi_write(A_STEP, 32'h0, 4'hF);
        push_frame(px(1, 1, 1, 1, 1, 1, 1, 1));
        push_frame(px(2, 2, 2, 2, 2, 2, 2, 2));
        axi_write(A_CTRL, 32'd1, 4'hF);
        axi_write(A_X0, 32'h1000_0000, 4'hF);
        t = 0;
        while (q.size() > NPIX && t < 500) begin @(negedge aclk); t++; end
        if (q.size() > NPIX) timeout("frame1_done");
        axi_write(A_CTRL, 32'd0, 4'hF);
        wait_idle("shadow");

        ready_mode = 2;
        axi_write(A_X0, 32'h0, 4'hF);
        push_frame(px(255, 255, 255, 255, 255, 255, 255, 255));
        axi_write(A_CTRL, 32'd1, 4'hF);
        t = 0;
        while (!m_axis_tvalid && t < 600) begin @(negedge aclk); t++; end
        if (!m_axis_tvalid) timeout("stalled_tvalid");
        repeat (3) @(negedge aclk);
        #2 areset = 1'b1;
        #1 check("reset_drops_tvalid", 32'(m_axis_tvalid), 32'd0);
        q.delete();
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        ready_mode = 0;
        axi_read(A_CTRL, d); check("post_rst_ctrl", d, 32'd0);
        axi_read(A_X0, d);   check("post_rst_x0", d, 32'd0);
        axi_write(A_X0, 32'h1122_3344, 4'hF);
        axi_write(A_X0, 32'hAABB_CCDD, 4'h1);
        axi_read(A_X0, d);   check("wstrb_byte0", d, 32'h1122_33DD);

        axi_write(A_X0, 32'h2000_0000, 4'hF);
        push_frame(px(1, 1, 1, 1, 1, 1, 1, 1));
        axi_write(A_CTRL, 32'd1, 4'hF);
        axi_write(A_CTRL, 32'd0, 4'hF);
        wait_idle("re_enable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
